hack_cpu_mc: RTL and testbench
==============================

# hack_cpu_mc

Parametrised multi-cycle Hack CPU core, successor to the single-cycle CPU. It executes the unchanged 16-bit Hack instruction set over a configurable data width. Instruction and data memory sit behind req/ready handshakes, so ROM and RAM may take any number of cycles. It adds a halt detector and a retire strobe, and it sits between the instruction ROM, the data RAM/memory-mapped I/O fabric, and the top-level debug logic.

## Interface
Parameters:
- WIDTH, 16, data/A/D/ALU width; legal values ≥16.
- PC_WIDTH, 15, program counter width; legal range 1..15.
- RESET_VECTOR, 0, PC value loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr_req  out  1  instruction fetch request.
- instr_addr  out  PC_WIDTH  fetch address, equals pc.
- instr_rdata  in  16  fetched instruction.
- instr_ready  in  1  fetch completes on an edge where instr_req && instr_ready.
- mem_req  out  1  data access request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  WIDTH  data address.
- mem_wdata  out  WIDTH  write data.
- mem_rdata  in  WIDTH  read data, sampled on the completing edge.
- mem_ready  in  1  data access completes on an edge where mem_req && mem_ready.
- pc  out  PC_WIDTH  current program counter.
- retire  out  1  one-cycle pulse on the edge where an instruction finishes.
- halted  out  1  core stopped in HALT.

## Operation
- Registers: A, D (WIDTH), pc (PC_WIDTH), IR (16), Y operand (WIDTH), write address/data latches.
- States: FETCH, MREAD, EXEC, MWRITE, HALT.
- FETCH: instr_req=1, instr_addr=pc. On completion, latch IR.
  - If IR[15]=1 and IR[12]=1, go to MREAD.
  - Otherwise go to EXEC.
- MREAD: mem_req=1, mem_we=0, mem_addr=A. On completion, Y←mem_rdata and go to EXEC.
- EXEC (exactly 1 cycle):
  - A-instruction: A←zero-extend(IR[14:0]) to WIDTH; pc←pc+1.
  - C-instruction: ALU x=D, y=(IR[12] ? Y : A). Controls zx,nx,zy,ny,f,no = IR[11:6], with standard Hack semantics at WIDTH bits.
  - Destinations: d1=IR[5] writes A, d2=IR[4] writes D, d3=IR[3] writes M.
  - On d3, latch write address=old A and write data=ALU out.
- Jump: zr = (out==0), ng = out[WIDTH-1].
  - Take the jump if (IR[2]&&ng) || (IR[1]&&zr) || (IR[0]&&!ng&&!zr).
  - Taken: pc←old A[PC_WIDTH-1:0]. Otherwise pc←pc+1, wrapping modulo 2^PC_WIDTH.
  - Jump target and M address always use the A value from before this instruction's d1 write.
- Next state after EXEC:
  - d3=1: go to MWRITE.
  - Halt condition (below): go to HALT.
  - Otherwise: go to FETCH.
- Halt condition: C-instruction with jjj=111, old A[PC_WIDTH-1:0]==pc, and d1=d2=d3=0 (the "@LOOP; 0;JMP" idiom).
- MWRITE: mem_req=1, mem_we=1, with the latched addr/data. On completion, go to FETCH.
- HALT: halted=1. No requests are issued and all state is frozen; only reset leaves HALT.
- retire pulses on the EXEC edge when d3=0, and on the MWRITE completion edge otherwise.

## Timing
- Reset (reset_n low, asynchronous):
  - State = FETCH, pc = RESET_VECTOR, A = D = IR = Y = 0.
  - instr_req = mem_req = mem_we = retire = halted = 0. Request outputs are masked while reset_n is low.
  - The first instr_req=1 appears in the first cycle after reset_n rises.
- Handshake rules:
  - req, addr, we and wdata stay stable from assertion until the completing edge.
  - ready may already be high when req rises; the access then completes at the same edge (zero wait).
  - ready while req=0 is ignored.
  - The core never withdraws a request.
- Latency with zero-wait memories:
  - A-instruction or non-M C-instruction: 2 cycles.
  - M-read: 3 cycles.
  - M-write: 3 cycles.
  - M read-modify-write (e.g. M=M+1): 4 cycles.
  - Each wait cycle on a ready line adds one cycle.
- Reset mid-access: the request drops immediately and the transfer is abandoned. Memory must tolerate an incomplete access.
- pc updates only at the EXEC edge; instr_addr is constant during a fetch.

## Test plan
- Reset and first fetch: hold reset_n low 3 cycles, then release → instr_req=1 at addr 0 next cycle; A=D=0; halted=0.
- A-load and arithmetic: @5; D=A; @7; D=D+A with zero-wait ROM → D=12 after 8 cycles; retire pulses 4 times.
- Memory path with waits: @100; M=1 (ready delayed 2 cycles); then M=M+1 → one write, one read, one write to addr 100; final RAM[100]=2; mem_wdata stable during every wait.
- AM=M-1 ordering: A=100, RAM[100]=50 → write of 49 goes to address 100 (old A); afterwards A=49.
- Jumps and wrap: D=-1 with D;JLT taken to A=20 (pc=20); D;JGT not taken; pc=2^PC_WIDTH-1 non-jump → pc wraps to 0; run at WIDTH=32 with D=0x80000000 → ng=1.
- Halt and reset mid-op: @3; 0;JMP at pc 3 → halted=1, no further requests for 20 cycles. Then assert reset_n low during a stalled mem write → mem_req=0 immediately; restart at RESET_VECTOR.

Source files
------------

// File: rtl/hack_cpu_mc_if.sv
// Instruction-fetch and data-memory handshake bus of the multi-cycle Hack core.
// The core is the master; ROM and RAM/MMIO fabric sit on the slave side.
interface hack_cpu_mc_if #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned PC_WIDTH = 15
);
    logic                instr_req;
    logic [PC_WIDTH-1:0] instr_addr;
    logic [15:0]         instr_rdata;
    logic                instr_ready;

    logic                mem_req;
    logic                mem_we;
    logic [WIDTH-1:0]    mem_addr;
    logic [WIDTH-1:0]    mem_wdata;
    logic [WIDTH-1:0]    mem_rdata;
    logic                mem_ready;

    modport master (
        output instr_req, instr_addr, mem_req, mem_we, mem_addr, mem_wdata,
        input  instr_rdata, instr_ready, mem_rdata, mem_ready
    );

    modport slave (
        input  instr_req, instr_addr, mem_req, mem_we, mem_addr, mem_wdata,
        output instr_rdata, instr_ready, mem_rdata, mem_ready
    );
endinterface

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU: FETCH -> (MREAD) -> EXEC -> (MWRITE), with halt detection
// on the "@LOOP; 0;JMP" idiom and a retire strobe per finished instruction.
module hack_cpu_mc #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned PC_WIDTH     = 15,
    parameter int unsigned RESET_VECTOR = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    hack_cpu_mc_if.master       bus,
    output logic [PC_WIDTH-1:0] pc,
    output logic                retire,
    output logic                halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_MREAD  = 3'd1,
        S_EXEC   = 3'd2,
        S_MWRITE = 3'd3,
        S_HALT   = 3'd4
    } state_e;

    state_e              state_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    d_q;
    logic [WIDTH-1:0]    y_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [15:0]         ir_q;
    logic [WIDTH-1:0]    maddr_q;
    logic [WIDTH-1:0]    wdata_q;
    logic                ireq_q;
    logic                mreq_q;
    logic                mwe_q;
    logic                retire_q;
    logic                halted_q;

    // Decode fields of the latched instruction
    logic       is_c;
    logic       use_m;
    logic       zx, nx, zy, ny, fn, no;
    logic       dst_a, dst_d, dst_m;
    logic [2:0] jmp;

    assign is_c  = ir_q[15];
    assign use_m = ir_q[12];
    assign zx    = ir_q[11];
    assign nx    = ir_q[10];
    assign zy    = ir_q[9];
    assign ny    = ir_q[8];
    assign fn    = ir_q[7];
    assign no    = ir_q[6];
    assign dst_a = ir_q[5];
    assign dst_d = ir_q[4];
    assign dst_m = ir_q[3];
    assign jmp   = ir_q[2:0];

    // Hack ALU at full data width
    logic [WIDTH-1:0] alu_x;
    logic [WIDTH-1:0] alu_y;
    logic [WIDTH-1:0] alu_out;

    always_comb begin
        alu_x = zx ? '0 : d_q;
        if (nx) alu_x = ~alu_x;
        alu_y = use_m ? y_q : a_q;
        if (zy) alu_y = '0;
        if (ny) alu_y = ~alu_y;
        alu_out = fn ? (alu_x + alu_y) : (alu_x & alu_y);
        if (no) alu_out = ~alu_out;
    end

    // Branch resolution; target and halt compare use A before any d1 write
    logic                zr;
    logic                ng;
    logic                take_jump;
    logic                halt_cond;
    logic [PC_WIDTH-1:0] a_tgt;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] pc_nxt;

    assign zr        = (alu_out == '0);
    assign ng        = alu_out[WIDTH-1];
    assign take_jump = (jmp[2] && ng) || (jmp[1] && zr) || (jmp[0] && !ng && !zr);
    assign a_tgt     = a_q[PC_WIDTH-1:0];
    assign pc_inc    = pc_q + PC_WIDTH'(1);
    assign pc_nxt    = (is_c && take_jump) ? a_tgt : pc_inc;
    assign halt_cond = (jmp == 3'b111) && (a_tgt == pc_q) && !dst_a && !dst_d && !dst_m;

    // Control FSM and architectural state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_FETCH;
            a_q      <= '0;
            d_q      <= '0;
            y_q      <= '0;
            pc_q     <= PC_WIDTH'(RESET_VECTOR);
            ir_q     <= '0;
            maddr_q  <= '0;
            wdata_q  <= '0;
            ireq_q   <= 1'b0;
            mreq_q   <= 1'b0;
            mwe_q    <= 1'b0;
            retire_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            retire_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (!ireq_q) begin
                        ireq_q <= 1'b1;
                    end else if (bus.instr_ready) begin
                        ireq_q <= 1'b0;
                        ir_q   <= bus.instr_rdata;
                        if (bus.instr_rdata[15] && bus.instr_rdata[12]) begin
                            mreq_q  <= 1'b1;
                            mwe_q   <= 1'b0;
                            maddr_q <= a_q;
                            state_q <= S_MREAD;
                        end else begin
                            state_q <= S_EXEC;
                        end
                    end
                end

                S_MREAD: begin
                    if (bus.mem_ready) begin
                        y_q     <= bus.mem_rdata;
                        mreq_q  <= 1'b0;
                        state_q <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    pc_q <= pc_nxt;
                    if (!is_c) begin
                        a_q      <= WIDTH'(ir_q[14:0]);
                        retire_q <= 1'b1;
                        ireq_q   <= 1'b1;
                        state_q  <= S_FETCH;
                    end else begin
                        if (dst_a) a_q <= alu_out;
                        if (dst_d) d_q <= alu_out;
                        if (dst_m) begin
                            mreq_q  <= 1'b1;
                            mwe_q   <= 1'b1;
                            maddr_q <= a_q;
                            wdata_q <= alu_out;
                            state_q <= S_MWRITE;
                        end else begin
                            retire_q <= 1'b1;
                            if (halt_cond) begin
                                halted_q <= 1'b1;
                                state_q  <= S_HALT;
                            end else begin
                                ireq_q  <= 1'b1;
                                state_q <= S_FETCH;
                            end
                        end
                    end
                end

                S_MWRITE: begin
                    if (bus.mem_ready) begin
                        mreq_q   <= 1'b0;
                        mwe_q    <= 1'b0;
                        retire_q <= 1'b1;
                        ireq_q   <= 1'b1;
                        state_q  <= S_FETCH;
                    end
                end

                S_HALT: begin
                end

                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

    assign bus.instr_req  = ireq_q;
    assign bus.instr_addr = pc_q;
    assign bus.mem_req    = mreq_q;
    assign bus.mem_we     = mwe_q;
    assign bus.mem_addr   = maddr_q;
    assign bus.mem_wdata  = wdata_q;

    assign pc     = pc_q;
    assign retire = retire_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Bench for hack_cpu_mc at WIDTH=32: directed programs plus random programs,
// checked against an instruction-level Hack interpreter and latency budget.
module tb_hack_cpu_mc;

    localparam int unsigned W   = 32;
    localparam int unsigned PW  = 15;
    localparam int unsigned NPC = 1 << PW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [PW-1:0] pc;
    logic          retire;
    logic          halted;

    hack_cpu_mc_if #(.WIDTH(W), .PC_WIDTH(PW)) bus ();

    hack_cpu_mc #(.WIDTH(W), .PC_WIDTH(PW), .RESET_VECTOR(0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .pc      (pc),
        .retire  (retire),
        .halted  (halted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Memories shared by the responders; the model keeps its own RAM copy
    logic [15:0]  rom [NPC];
    logic [W-1:0] ram [int];
    logic [W-1:0] m_ram [int];

    function automatic logic [W-1:0] ram_rd(input logic [W-1:0] a);
        return ram.exists(int'(a)) ? ram[int'(a)] : '0;
    endfunction

    function automatic logic [W-1:0] mram_rd(input logic [W-1:0] a);
        return m_ram.exists(int'(a)) ? m_ram[int'(a)] : '0;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < int'(NPC); i++) rom[i] = 16'h0000;
        ram.delete();
        m_ram.delete();
    endtask

    task automatic preload(input int a, input logic [W-1:0] v);
        ram[a]   = v;
        m_ram[a] = v;
    endtask

    function automatic logic [15:0] a_ins(input int unsigned v);
        return {1'b0, 15'(v)};
    endfunction

    function automatic logic [15:0] c_ins(input logic a, input logic [5:0] comp,
                                          input logic [2:0] dest, input logic [2:0] jj);
        return {3'b111, a, comp, dest, jj};
    endfunction

    // Memory responders with randomised wait states
    int i_wmin = 0, i_wmax = 0, m_wmin = 0, m_wmax = 0;
    int i_cnt = 0, i_wait = 0, m_cnt = 0, m_wait = 0;
    bit m_stall = 0;
    int wait_total = 0;
    int n_wr = 0, n_rd = 0;
    logic [W-1:0] wr_addr_q[$];
    logic [W-1:0] wr_data_q[$];
    logic [W-1:0] rd_addr_q[$];

    bit            i_pend = 0, m_pend = 0;
    logic [PW-1:0] sv_iaddr;
    logic [W-1:0]  sv_maddr, sv_wdata;
    logic          sv_we;

    initial begin
        bus.instr_ready = 1'b0;
        bus.instr_rdata = '0;
        bus.mem_ready   = 1'b0;
        bus.mem_rdata   = '0;
    end

    always @(negedge clk) begin
        if (bus.instr_req === 1'b1) begin
            if (i_cnt >= i_wait) begin
                bus.instr_ready = 1'b1;
                bus.instr_rdata = rom[bus.instr_addr];
            end else begin
                bus.instr_ready = 1'b0;
                bus.instr_rdata = 16'($urandom);
                i_cnt++;
            end
        end else begin
            bus.instr_ready = 1'($urandom_range(0, 1));
            bus.instr_rdata = 16'($urandom);
        end
        if (bus.mem_req === 1'b1) begin
            if (!m_stall && m_cnt >= m_wait) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = ram_rd(bus.mem_addr);
            end else begin
                bus.mem_ready = 1'b0;
                bus.mem_rdata = W'($urandom);
                m_cnt++;
            end
        end else begin
            bus.mem_ready = 1'($urandom_range(0, 1));
            bus.mem_rdata = W'($urandom);
        end
    end

    always @(posedge clk) begin
        if (!reset_n) begin
            i_cnt  = 0;
            m_cnt  = 0;
            i_pend = 0;
            m_pend = 0;
            i_wait = $urandom_range(i_wmin, i_wmax);
            m_wait = $urandom_range(m_wmin, m_wmax);
        end else begin
            if (i_pend) begin
                chk("instr_hold_req", bus.instr_req, 1'b1);
                chk("instr_hold_addr", bus.instr_addr, sv_iaddr);
            end
            if (m_pend) begin
                chk("mem_hold_req", bus.mem_req, 1'b1);
                chk("mem_hold_we", bus.mem_we, sv_we);
                chk("mem_hold_addr", bus.mem_addr, sv_maddr);
                if (sv_we) chk("mem_hold_wdata", bus.mem_wdata, sv_wdata);
            end
            i_pend   = bus.instr_req && !bus.instr_ready;
            sv_iaddr = bus.instr_addr;
            m_pend   = bus.mem_req && !bus.mem_ready;
            sv_maddr = bus.mem_addr;
            sv_wdata = bus.mem_wdata;
            sv_we    = bus.mem_we;
            if (bus.instr_req && bus.instr_ready) begin
                wait_total += i_cnt;
                i_cnt  = 0;
                i_wait = $urandom_range(i_wmin, i_wmax);
            end
            if (bus.mem_req && bus.mem_ready) begin
                wait_total += m_cnt;
                m_cnt  = 0;
                m_wait = $urandom_range(m_wmin, m_wmax);
                if (bus.mem_we) begin
                    ram[int'(bus.mem_addr)] = bus.mem_wdata;
                    wr_addr_q.push_back(bus.mem_addr);
                    wr_data_q.push_back(bus.mem_wdata);
                    n_wr++;
                end else begin
                    rd_addr_q.push_back(bus.mem_addr);
                    n_rd++;
                end
            end
        end
    end

    // Instruction-level reference model
    logic [W-1:0] m_a, m_d;
    int unsigned  m_pc;
    bit           m_halted;
    int           m_lat_sum;
    int           ret_cyc[$];
    int unsigned  pc_trace[$];

    task automatic model_step(output bit erd, output logic [W-1:0] ra, output bit ewr,
                              output logic [W-1:0] wa, output logic [W-1:0] wd);
        logic [15:0]  ins;
        logic [W-1:0] old_a, x, y, o;
        bit           lt, eq, gt, taken;
        int unsigned  tgt;
        ins   = rom[PW'(m_pc)];
        old_a = m_a;
        tgt   = old_a % NPC;
        erd = 0; ewr = 0; ra = '0; wa = '0; wd = '0;
        if (!ins[15]) begin
            m_a  = W'(ins[14:0]);
            m_pc = (m_pc + 1) % NPC;
            m_lat_sum += 2;
        end else begin
            if (ins[12]) begin erd = 1; ra = old_a; end
            x = ins[11] ? '0 : m_d;
            if (ins[10]) x = ~x;
            y = ins[12] ? mram_rd(old_a) : old_a;
            if (ins[9]) y = '0;
            if (ins[8]) y = ~y;
            o = ins[7] ? x + y : x & y;
            if (ins[6]) o = ~o;
            lt = $signed(o) < 0;
            eq = (o == '0);
            gt = $signed(o) > 0;
            taken = (ins[2] && lt) || (ins[1] && eq) || (ins[0] && gt);
            if (ins[2:0] == 3'b111 && ins[5:3] == 3'b000 && tgt == m_pc) m_halted = 1;
            if (ins[5]) m_a = o;
            if (ins[4]) m_d = o;
            if (ins[3]) begin
                ewr = 1; wa = old_a; wd = o;
                m_ram[int'(old_a)] = o;
            end
            m_pc = taken ? tgt : (m_pc + 1) % NPC;
            m_lat_sum += 2 + int'(ins[12]) + int'(ins[3]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_instr_req", bus.instr_req, 1'b0);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_retire", retire, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_pc", pc, 0);
        m_a = '0; m_d = '0; m_pc = 0; m_halted = 0; m_lat_sum = 0;
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
        ret_cyc.delete(); pc_trace.delete();
        wait_total = 0; n_wr = 0; n_rd = 0;
        reset_n = 1'b1;
    endtask

    // Runs from reset release until the model halts or max_ret instructions retire
    task automatic run_prog(input string tag, input int max_ret, input int budget);
        int cyc, nret, last;
        bit done, erd, ewr;
        logic [W-1:0] ra, wa, wd;
        cyc = 0; nret = 0; last = 0; done = 0;
        while (!done && cyc < budget) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == 1) begin
                chk({tag, "_first_req"}, bus.instr_req, 1'b1);
                chk({tag, "_first_addr"}, bus.instr_addr, 0);
            end
            if (retire === 1'b1) begin
                nret++;
                last = cyc;
                ret_cyc.push_back(cyc);
                model_step(erd, ra, ewr, wa, wd);
                if (erd) begin
                    chk({tag, "_read_seen"}, 64'(rd_addr_q.size() != 0), 1);
                    if (rd_addr_q.size() != 0) chk({tag, "_read_addr"}, rd_addr_q.pop_front(), ra);
                end
                if (ewr) begin
                    chk({tag, "_write_seen"}, 64'(wr_addr_q.size() != 0), 1);
                    if (wr_addr_q.size() != 0) begin
                        chk({tag, "_write_addr"}, wr_addr_q.pop_front(), wa);
                        chk({tag, "_write_data"}, wr_data_q.pop_front(), wd);
                    end
                end
                chk({tag, "_pc"}, pc, m_pc);
                pc_trace.push_back(m_pc);
                if (m_halted || nret == max_ret) done = 1;
            end
            chk({tag, "_halted"}, halted, m_halted);
        end
        chk({tag, "_completed"}, 64'(done), 1);
        chk({tag, "_cycles"}, last, 1 + m_lat_sum + wait_total);
        chk({tag, "_no_extra_reads"}, rd_addr_q.size(), 0);
        chk({tag, "_no_extra_writes"}, wr_addr_q.size(), 0);
    endtask

    initial begin
        int n, found, early;

        // D=12 arithmetic with zero-wait memories
        clear_mem();
        i_wmin = 0; i_wmax = 0; m_wmin = 0; m_wmax = 0;
        rom[0] = a_ins(5);
        rom[1] = c_ins(1'b0, 6'b110000, 3'b010, 3'b000);
        rom[2] = a_ins(7);
        rom[3] = c_ins(1'b0, 6'b000010, 3'b010, 3'b000);
        rom[4] = a_ins(100);
        rom[5] = c_ins(1'b0, 6'b001100, 3'b001, 3'b000);
        rom[6] = a_ins(7);
        rom[7] = c_ins(1'b0, 6'b101010, 3'b000, 3'b111);
        do_reset();
        run_prog("arith", 100, 200);
        chk("arith_4th_retire", ret_cyc[3], 9);
        early = 0;
        foreach (ret_cyc[k]) if (ret_cyc[k] <= 9) early++;
        chk("arith_retires_in_8", early, 4);
        chk("arith_d_is_12", ram_rd(100), 12);

        // Write, read-modify-write with two wait cycles on every data access
        clear_mem();
        m_wmin = 2; m_wmax = 2;
        rom[0] = a_ins(100);
        rom[1] = c_ins(1'b0, 6'b111111, 3'b001, 3'b000);
        rom[2] = c_ins(1'b1, 6'b110111, 3'b001, 3'b000);
        rom[3] = a_ins(4);
        rom[4] = c_ins(1'b0, 6'b101010, 3'b000, 3'b111);
        do_reset();
        run_prog("mwait", 100, 300);
        chk("mwait_writes", n_wr, 2);
        chk("mwait_reads", n_rd, 1);
        chk("mwait_ram100", ram_rd(100), 2);

        // AM=M-1 writes to the old A
        clear_mem();
        i_wmin = 0; i_wmax = 3; m_wmin = 0; m_wmax = 3;
        preload(100, 50);
        rom[0] = a_ins(100);
        rom[1] = c_ins(1'b1, 6'b110010, 3'b101, 3'b000);
        rom[2] = c_ins(1'b0, 6'b110000, 3'b010, 3'b000);
        rom[3] = a_ins(200);
        rom[4] = c_ins(1'b0, 6'b001100, 3'b001, 3'b000);
        rom[5] = a_ins(6);
        rom[6] = c_ins(1'b0, 6'b101010, 3'b000, 3'b111);
        do_reset();
        run_prog("amdec", 100, 400);
        chk("amdec_ram100", ram_rd(100), 49);
        chk("amdec_new_a", ram_rd(200), 49);

        // Conditional jumps and pc wrap
        clear_mem();
        i_wmin = 0; i_wmax = 1; m_wmin = 0; m_wmax = 1;
        rom[0]     = c_ins(1'b0, 6'b111010, 3'b010, 3'b000);
        rom[1]     = a_ins(20);
        rom[2]     = c_ins(1'b0, 6'b001100, 3'b000, 3'b100);
        rom[20]    = c_ins(1'b0, 6'b001100, 3'b000, 3'b001);
        rom[21]    = a_ins(NPC - 1);
        rom[22]    = c_ins(1'b0, 6'b101010, 3'b000, 3'b111);
        rom[NPC-1] = c_ins(1'b0, 6'b011111, 3'b010, 3'b000);
        do_reset();
        run_prog("jump", 7, 200);
        chk("jump_jlt_taken", pc_trace[2], 20);
        chk("jump_jgt_not_taken", pc_trace[3], 21);
        chk("jump_to_top", pc_trace[5], NPC - 1);
        chk("jump_wrap", pc_trace[6], 0);

        // Sign bit at bit 31
        clear_mem();
        preload(300, 32'h8000_0000);
        rom[0]  = a_ins(300);
        rom[1]  = c_ins(1'b1, 6'b110000, 3'b010, 3'b000);
        rom[2]  = a_ins(10);
        rom[3]  = c_ins(1'b0, 6'b001100, 3'b000, 3'b001);
        rom[4]  = c_ins(1'b0, 6'b001100, 3'b000, 3'b100);
        rom[10] = a_ins(11);
        rom[11] = c_ins(1'b0, 6'b101010, 3'b000, 3'b111);
        do_reset();
        run_prog("neg32", 100, 200);
        chk("neg32_jgt_not_taken", pc_trace[3], 4);
        chk("neg32_jlt_taken", pc_trace[4], 10);

        // Halt freezes the core
        clear_mem();
        rom[0] = a_ins(5);
        rom[1] = c_ins(1'b0, 6'b110000, 3'b010, 3'b000);
        rom[2] = a_ins(3);
        rom[3] = c_ins(1'b0, 6'b101010, 3'b000, 3'b111);
        do_reset();
        run_prog("halt", 100, 200);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("halt_no_req", {bus.instr_req, bus.mem_req}, 2'b00);
            chk("halt_pc_frozen", pc, 3);
            chk("halt_stays", halted, 1'b1);
        end

        // Reset during a stalled write
        clear_mem();
        i_wmin = 0; i_wmax = 0; m_wmin = 0; m_wmax = 0;
        rom[0] = a_ins(100);
        rom[1] = c_ins(1'b0, 6'b111111, 3'b001, 3'b000);
        rom[2] = a_ins(3);
        rom[3] = c_ins(1'b0, 6'b101010, 3'b000, 3'b111);
        m_stall = 1;
        do_reset();
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (bus.mem_req === 1'b1 && bus.mem_we === 1'b1) found = 1;
        end
        chk("stall_write_seen", found, 1);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_mem_req", bus.mem_req, 1'b0);
        chk("midrst_instr_req", bus.instr_req, 1'b0);
        chk("midrst_pc", pc, 0);
        chk("midrst_writes", n_wr, 0);
        m_stall = 0;
        do_reset();
        run_prog("restart", 100, 200);
        chk("restart_ram100", ram_rd(100), 1);

        // Random programs against the interpreter
        for (int t = 0; t < 6; t++) begin
            clear_mem();
            n = 24;
            i_wmin = 0; i_wmax = t % 4; m_wmin = 0; m_wmax = 3 - (t % 4);
            for (int i = 0; i < n; i++) begin
                preload(i, W'($urandom));
                if ($urandom_range(0, 99) < 35)
                    rom[i] = a_ins($urandom_range(0, n - 1));
                else
                    rom[i] = c_ins(1'($urandom), 6'($urandom), 3'($urandom),
                                   ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000);
            end
            rom[n]     = a_ins(0);
            rom[n + 1] = c_ins(1'b0, 6'b101010, 3'b000, 3'b111);
            do_reset();
            run_prog("rand", 150, 3000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
